// File: rtl/bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_pkg : shared size encodings, FSM states, access legality     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package bus_pkg;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Alignment/size legality only; the address window is checked by the slave.
  function automatic logic legal_access(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    legal_access = 1'b1;
      SZ_H:    legal_access = ~addr_lo[0];
      SZ_W:    legal_access = (addr_lo == 2'b00);
      default: legal_access = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_lane_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_lane_align : byte enables and lane-shifted store data        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module bus_lane_align
  import bus_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  output logic        misalign
);

  always_comb begin
    misalign   = ~legal_access(size, addr_lo);
    lane_wdata = wdata << {addr_lo, 3'b000};
    byte_en    = 4'b0000;
    case (size)
      SZ_B:    byte_en = 4'b0001 << addr_lo;
      SZ_H:    byte_en = 4'b0011 << addr_lo;
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    if (misalign) byte_en = 4'b0000;
  end

endmodule
`default_nettype wire

// File: rtl/bus_sram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_sram : word-aligned data-memory slave with wait states and   |
// |            a host fill/readback port                    rev 1.0  |
// +------------------------------------------------------------------+
module bus_sram
  import bus_pkg::*;
#(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          valid,
  input  logic          write,
  input  logic [2:0]    size,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          ready,
  output logic          err,
  input  logic          host_we,
  input  logic          host_re,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata
);

  localparam int DEPTH = 1 << AW;

  state_t        state, state_next;
  logic [3:0]    count, count_next;
  logic          req_write;
  logic [2:0]    req_size;
  logic [31:0]   req_addr, req_wdata;

  logic          cur_write;
  logic [2:0]    cur_size;
  logic [31:0]   cur_addr, cur_wdata;
  logic [31:0]   offset;
  logic          in_range, illegal, commit, bus_we, misalign;
  logic [AW-1:0] index;
  logic [3:0]    byte_en;
  logic [31:0]   lane_wdata;

  logic [31:0]   mem [DEPTH];

  // With zero wait states accept and commit share an edge, so the live bus is used in IDLE.
  assign cur_write = (state == IDLE) ? write : req_write;
  assign cur_size  = (state == IDLE) ? size  : req_size;
  assign cur_addr  = (state == IDLE) ? addr  : req_addr;
  assign cur_wdata = (state == IDLE) ? wdata : req_wdata;

  assign offset   = cur_addr - BASE;
  assign in_range = (offset >> (AW + 2)) == 32'd0;
  assign index    = offset[AW+1:2];
  assign illegal  = misalign | ~in_range;
  assign commit   = (state_next == RESP);
  assign bus_we   = commit & cur_write & ~illegal & rstb;

  bus_lane_align u_align (
    .size       (cur_size),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .byte_en    (byte_en),
    .lane_wdata (lane_wdata),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      count     <= 4'd0;
      req_write <= 1'b0;
      req_size  <= 3'd0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == IDLE && valid) begin
        req_write <= write;
        req_size  <= size;
        req_addr  <= addr;
        req_wdata <= wdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (valid) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            count_next = 4'(WAIT_STATES - 1);
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) state_next = RESP;
        else               count_next = count - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready      <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'd0;
      host_rdata <= 32'd0;
    end else begin
      ready <= commit;
      err   <= commit & illegal;
      if (commit && illegal)         rdata <= 32'd0;
      else if (commit && !cur_write) rdata <= mem[index];
      if (host_re) host_rdata <= mem[host_addr];
    end
  end

  // Bus byte writes come after the host word write so they win on enabled lanes.
  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (bus_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[index][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_sram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bus_sram : directed scoreboard bench, three wait-state builds |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_bus_sram;
  import bus_pkg::*;

  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk  = 1'b0;
  logic          rstb = 1'b0;
  logic [2:0]    valid   = '0;
  logic [2:0]    host_we = '0;
  logic [2:0]    host_re = '0;
  logic          write = 1'b0;
  logic [2:0]    size  = 3'd0;
  logic [31:0]   addr  = 32'd0;
  logic [31:0]   wdata = 32'd0;
  logic [AW-1:0] host_addr  = '0;
  logic [31:0]   host_wdata = 32'd0;
  logic [31:0]   rdata [3];
  logic [31:0]   host_rdata [3];
  logic [2:0]    ready, err;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q [$];

  always #5 clk = ~clk;

  // Instance 0: no wait states, 1: three, 2: four.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      bus_sram #(
        .AW          (AW),
        .BASE        (BASE),
        .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 4)
      ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .valid      (valid[g]),
        .write      (write),
        .size       (size),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata[g]),
        .ready      (ready[g]),
        .err        (err[g]),
        .host_we    (host_we[g]),
        .host_re    (host_re[g]),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata[g])
      );
    end
  endgenerate

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int d, input logic [AW-1:0] idx, input logic [31:0] data);
    @(negedge clk);
    host_addr  = idx;
    host_wdata = data;
    host_we[d] = 1'b1;
    @(posedge clk);
    #1 host_we[d] = 1'b0;
  endtask

  task automatic host_read(input int d, input logic [AW-1:0] idx, output logic [31:0] data);
    @(negedge clk);
    host_addr  = idx;
    host_re[d] = 1'b1;
    @(posedge clk);
    #1 host_re[d] = 1'b0;
    data = host_rdata[d];
  endtask

  // One bus transaction; the bus lines are scrambled after accept to prove they are latched.
  task automatic bus_op(input int d, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] old_rd;
    logic [32:0] exp;
    int          cyc;
    sb_q.push_back({exp_rd, exp_err});
    @(negedge clk);
    write = wr; size = sz; addr = a; wdata = wd; valid[d] = 1'b1;
    old_rd = rdata[d];
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
      if (!ready[d] && cyc < 40) begin
        check("wait_rdata_hold", rdata[d], old_rd);
        check("wait_err_low", {31'd0, err[d]}, 32'd0);
        if (cyc == 1) begin
          addr = 32'hFFFF_FFF3; size = 3'd7; wdata = ~wd; write = ~wr;
        end
      end
    end while (!ready[d] && cyc < 40);
    valid[d] = 1'b0;
    check("latency", 32'(cyc), 32'(ws_of(d) + 1));
    exp = sb_q.pop_front();
    check("rdata", rdata[d], exp[32:1]);
    check("err", {31'd0, err[d]}, {31'd0, exp[0]});
    @(posedge clk);
    #1 check("ready_one_cycle", {31'd0, ready[d]}, 32'd0);
    check("err_one_cycle", {31'd0, err[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", {31'd0, ready[d]}, 32'd0);
      check("rst_err", {31'd0, err[d]}, 32'd0);
      check("rst_rdata", rdata[d], 32'd0);
      check("rst_host_rdata", host_rdata[d], 32'd0);
    end
    @(negedge clk) rstb = 1'b1;

    // Zero wait states: word, byte, half stores and loads.
    bus_op(0, 1'b1, SZ_W, 32'h24, 32'hDEAD_BEEF, 32'h0, 1'b0);
    bus_op(0, 1'b0, SZ_W, 32'h24, 32'h0, 32'hDEAD_BEEF, 1'b0);
    host_read(0, 10'd9, v);
    check("host_rd_idx9_word", v, 32'hDEAD_BEEF);
    host_write(0, 10'd9, 32'h1122_3344);
    bus_op(0, 1'b1, SZ_B, 32'h26, 32'h0000_00AB, 32'hDEAD_BEEF, 1'b0);
    host_read(0, 10'd9, v);
    check("host_rd_after_sb", v, 32'h11AB_3344);
    bus_op(0, 1'b0, SZ_B, 32'h26, 32'h0, 32'h11AB_3344, 1'b0);
    host_write(0, 10'd8, 32'h5555_5555);
    bus_op(0, 1'b1, SZ_H, 32'h22, 32'hFFFF_BEEF, 32'h11AB_3344, 1'b0);
    host_read(0, 10'd8, v);
    check("host_rd_after_sh", v, 32'hBEEF_5555);

    // Illegal accesses.
    bus_op(0, 1'b1, SZ_H, 32'h21, 32'h0000_1234, 32'h0, 1'b1);
    host_read(0, 10'd8, v);
    check("host_rd_after_bad_sh", v, 32'hBEEF_5555);
    bus_op(0, 1'b0, SZ_W, 32'h24, 32'h0, 32'h11AB_3344, 1'b0);
    bus_op(0, 1'b0, SZ_W, BASE + 32'h1000, 32'h0, 32'h0, 1'b1);
    bus_op(0, 1'b0, SZ_W, 32'h24, 32'h0, 32'h11AB_3344, 1'b0);
    bus_op(0, 1'b0, 3'd3, 32'h24, 32'h0, 32'h0, 1'b1);
    bus_op(0, 1'b1, SZ_W, 32'h26, 32'h0, 32'h0, 1'b1);
    host_read(0, 10'd9, v);
    check("host_rd_after_bad_sw", v, 32'h11AB_3344);

    // Host and bus write the same word on the same edge.
    @(negedge clk);
    host_addr = 10'd5; host_wdata = 32'hFFFF_FFFF; host_we[0] = 1'b1;
    write = 1'b1; size = SZ_B; addr = 32'h15; wdata = 32'h0; valid[0] = 1'b1;
    @(posedge clk);
    #1 host_we[0] = 1'b0;
    valid[0] = 1'b0;
    check("collide_ready", {31'd0, ready[0]}, 32'd1);
    check("collide_err", {31'd0, err[0]}, 32'd0);
    host_read(0, 10'd5, v);
    check("collide_word", v, 32'hFFFF_00FF);

    // Three wait states.
    host_write(1, 10'd2, 32'hA5A5_A5A5);
    bus_op(1, 1'b0, SZ_W, 32'h08, 32'h0, 32'hA5A5_A5A5, 1'b0);
    bus_op(1, 1'b1, SZ_B, 32'h0B, 32'h0000_0077, 32'hA5A5_A5A5, 1'b0);
    host_read(1, 10'd2, v);
    check("ws3_sb_word", v, 32'h77A5_A5A5);

    // Four wait states, reset pulsed while a store is waiting.
    host_write(2, 10'd3, 32'h0);
    @(negedge clk);
    write = 1'b1; size = SZ_W; addr = 32'h0C; wdata = 32'hCAFE_F00D; valid[2] = 1'b1;
    @(posedge clk);
    #1 valid[2] = 1'b0;
    @(posedge clk);
    #1 check("pre_rst_ready", {31'd0, ready[2]}, 32'd0);
    @(negedge clk) rstb = 1'b0;
    #1 check("in_rst_ready", {31'd0, ready[2]}, 32'd0);
    @(negedge clk) rstb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("post_rst_ready", {31'd0, ready[2]}, 32'd0);
    end
    host_read(2, 10'd3, v);
    check("rst_store_dropped", v, 32'h0);
    bus_op(2, 1'b1, SZ_W, 32'h0C, 32'h1234_5678, 32'h0, 1'b0);
    bus_op(2, 1'b0, SZ_W, 32'h0C, 32'h0, 32'h1234_5678, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
